vdp_bus_master: RTL and testbench
=================================

# vdp_bus_master

Host-side bus initiator for the VDP CPU port. It turns single-beat commands from a valid/ready command channel into 68000-style bus cycles on `SEL/A/RNW/UDS_N/LDS_N/DI`. It waits for the VDP's `DTACK_N`, returns read data or status on a valid/ready response channel, and drives the `vdp_*` nets in `sega_genesis_top` on `vdp_clk`.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles that address, RNW and write data are held before strobes assert; minimum 1.
- `RECOVERY_CYCLES`, default 1: idle cycles after `DTACK_N` is seen high, before the response is issued; minimum 1.
- `TIMEOUT_CYCLES`, default 255: maximum wait for each `DTACK_N` edge; used only with `VDP_BUS_TIMEOUT_EN`.

Ports:
- `CLK` in 1: the single clock, `vdp_clk`.
- `RST_N` in 1: reset, synchronous and active-low.
- `CMD_VALID` in 1, `CMD_READY` out 1: command handshake.
- `CMD_RNW` in 1: 1 = read, 0 = write.
- `CMD_ADDR` in 5: VDP port address.
- `CMD_DATA` in 16: write data.
- `CMD_BE` in 2: byte enables; bit 1 = upper byte (`UDS`), bit 0 = lower byte (`LDS`).
- `RSP_VALID` out 1, `RSP_READY` in 1: response handshake.
- `RSP_DATA` out 16: read data; 0 for writes and errors.
- `RSP_ERR` out 1: command failed.
- `VDP_SEL` out 1: chip select, active high.
- `VDP_A` out 5, `VDP_RNW` out 1, `VDP_UDS_N` out 1, `VDP_LDS_N` out 1, `VDP_DI` out 16: bus cycle outputs.
- `VDP_DO` in 16, `VDP_DTACK_N` in 1: VDP read data and acknowledge.

## Operation
- States: IDLE, SETUP, STROBE, RELEASE, RESP.
- All outputs except `CMD_READY` are registered.
- `CMD_READY = RST_N && state==IDLE`.
- IDLE:
  - On `CMD_VALID && CMD_READY`, latch the command.
  - If `CMD_BE==2'b00`: go to RESP with `RSP_ERR=1`, `RSP_DATA=0`, and run no bus cycle.
  - Otherwise go to SETUP. Drive `VDP_A=CMD_ADDR` and `VDP_RNW=CMD_RNW`. Drive `VDP_DI=CMD_DATA` on writes, 0 on reads.
- SETUP: hold for `SETUP_CYCLES` cycles, then go to STROBE. Assert `VDP_SEL=1`, `VDP_UDS_N=~BE[1]`, `VDP_LDS_N=~BE[0]`.
- STROBE: hold all bus outputs until `VDP_DTACK_N` is sampled 0.
  - On reads, capture `VDP_DO` in that cycle. Zero any byte whose enable is clear.
  - Then go to RELEASE: `VDP_SEL=0`, both strobes 1, `VDP_RNW=1`, `VDP_DI=0`. `VDP_A` keeps its last value.
- RELEASE:
  - Wait for `VDP_DTACK_N` sampled 1.
  - Then count `RECOVERY_CYCLES`.
  - Then go to RESP with `RSP_VALID=1` and `RSP_ERR=0`.
- RESP:
  - Hold `RSP_VALID`, `RSP_DATA` and `RSP_ERR` stable until `RSP_READY` is sampled 1.
  - Then go to IDLE with `RSP_VALID=0`.
  - `RSP_READY` while `RSP_VALID=0` is ignored.
- One command in flight at a time; there is no queue. A new command can be accepted no earlier than the cycle after the response handshake.
- `VDP_DTACK_N` low while in IDLE or SETUP is ignored.

## Timing
- Reset values, at the first rising edge with `RST_N=0`:
  - state IDLE.
  - `VDP_SEL=0`, `VDP_A=0`, `VDP_RNW=1`, `VDP_UDS_N=1`, `VDP_LDS_N=1`, `VDP_DI=0`.
  - `RSP_VALID=0`, `RSP_DATA=0`, `RSP_ERR=0`.
  - All counters 0.
- Reset mid-operation: the same reset values apply at that edge. The in-flight command is dropped and no response is issued. Strobes deassert at that edge.
- Latency, counted from the command-accept edge to the edge where `RSP_VALID` rises: minimum `SETUP_CYCLES + RECOVERY_CYCLES + 2`. The minimum occurs when `DTACK_N` is low at the first STROBE sample and high at the first RELEASE sample. Each extra cycle of `DTACK_N` delay adds 1.
- `CMD_BE==0` error response: `RSP_VALID` rises at the accept edge.
- Strobes and `VDP_SEL` assert and deassert on the same edge. Address, RNW and data are stable from SETUP through the end of STROBE.

## Configuration
- `VDP_BUS_TIMEOUT_EN` defined:
  - One counter clears on entry to STROBE and on entry to RELEASE, and increments each cycle spent waiting.
  - Reaching `TIMEOUT_CYCLES` in STROBE: go to RELEASE and set `RSP_ERR=1`, `RSP_DATA=0`.
  - Reaching `TIMEOUT_CYCLES` in RELEASE: set `RSP_ERR=1` and go to RESP without waiting for `DTACK_N` high.
  - The error flag is sticky until the response handshake completes.
- `VDP_BUS_TIMEOUT_EN` not defined:
  - No counter; the block waits indefinitely on `DTACK_N`.
  - `RSP_ERR` is set only for `CMD_BE==0`.

## Test plan
- Write `ADDR=5'h04`, `DATA=16'h8144`, `BE=2'b11`, with the VDP model acking 1 cycle into STROBE. Expect:
  - `VDP_DI=16'h8144` and `VDP_SEL=1` with both strobes low for exactly 1 cycle.
  - `RSP_VALID` at accept+4 with defaults, `RSP_ERR=0`, `RSP_DATA=0`.
- Read `ADDR=5'h00`, `BE=2'b10`, with `VDP_DO=16'hABCD` and the ack delayed 3 cycles. Expect `VDP_UDS_N=0`, `VDP_LDS_N=1`, `RSP_DATA=16'hAB00`, and latency 7.
- `CMD_BE=2'b00`: expect no `VDP_SEL` pulse, and `RSP_VALID` with `RSP_ERR=1` one cycle after accept.
- Hold `RSP_READY=0` for 10 cycles after a read: expect response fields stable, `CMD_READY=0`, and a second `CMD_VALID` not accepted until after the handshake.
- Drive `RST_N=0` for one edge during STROBE: expect all outputs at reset values the next cycle, no response, and `CMD_READY=1` once `RST_N=1`.
- With `VDP_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, never ack. Expect strobes released after 8 STROBE cycles, then `RSP_ERR=1`, `RSP_DATA=0`.

Source files
------------

// File: rtl/vdp_bus_master_if.sv
// Command/response channels and VDP CPU-port bus signals of vdp_bus_master.
// master = the bus initiator's view, slave = the host/VDP side.
interface vdp_bus_master_if;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        CMD_RNW;
   logic [4:0]  CMD_ADDR;
   logic [15:0] CMD_DATA;
   logic [1:0]  CMD_BE;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [15:0] RSP_DATA;
   logic        RSP_ERR;
   logic        VDP_SEL;
   logic [4:0]  VDP_A;
   logic        VDP_RNW;
   logic        VDP_UDS_N;
   logic        VDP_LDS_N;
   logic [15:0] VDP_DI;
   logic [15:0] VDP_DO;
   logic        VDP_DTACK_N;

   modport master (
      input  CMD_VALID, CMD_RNW, CMD_ADDR, CMD_DATA, CMD_BE, RSP_READY, VDP_DO, VDP_DTACK_N,
      output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
      output VDP_SEL, VDP_A, VDP_RNW, VDP_UDS_N, VDP_LDS_N, VDP_DI
   );

   modport slave (
      output CMD_VALID, CMD_RNW, CMD_ADDR, CMD_DATA, CMD_BE, RSP_READY, VDP_DO, VDP_DTACK_N,
      input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR,
      input  VDP_SEL, VDP_A, VDP_RNW, VDP_UDS_N, VDP_LDS_N, VDP_DI
   );
endinterface

// File: rtl/vdp_bus_master.sv
// Turns single-beat valid/ready commands into 68000-style VDP bus cycles.
// Define VDP_BUS_TIMEOUT_EN to add a DTACK_N watchdog that errors out stalled cycles.
module vdp_bus_master #(
   parameter int SETUP_CYCLES    = 1,
   parameter int RECOVERY_CYCLES = 1,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input logic              CLK,
   input logic              RST_N,
   vdp_bus_master_if.master bus
);
   // One counter serves setup, recovery and the watchdog, so it is sized for the largest.
   localparam int SR_MAX  = (SETUP_CYCLES > RECOVERY_CYCLES) ? SETUP_CYCLES : RECOVERY_CYCLES;
   localparam int CNT_MAX = (SR_MAX > TIMEOUT_CYCLES) ? SR_MAX : TIMEOUT_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVERY_CYCLES - 1);
`ifdef VDP_BUS_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_RESP} state_t;

   state_t            r_state, w_state;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              r_seen, w_seen;
   logic [1:0]        r_be, w_be;
   logic              r_sel, w_sel;
   logic [4:0]        r_a, w_a;
   logic              r_rnw, w_rnw;
   logic              r_uds_n, w_uds_n;
   logic              r_lds_n, w_lds_n;
   logic [15:0]       r_di, w_di;
   logic              r_rsp_valid, w_rsp_valid;
   logic [15:0]       r_rsp_data, w_rsp_data;
   logic              r_rsp_err, w_rsp_err;
   logic              w_release;

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_seen      = r_seen;
      w_be        = r_be;
      w_sel       = r_sel;
      w_a         = r_a;
      w_rnw       = r_rnw;
      w_uds_n     = r_uds_n;
      w_lds_n     = r_lds_n;
      w_di        = r_di;
      w_rsp_valid = r_rsp_valid;
      w_rsp_data  = r_rsp_data;
      w_rsp_err   = r_rsp_err;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.CMD_VALID) begin
               w_be       = bus.CMD_BE;
               w_cnt      = '0;
               w_rsp_data = '0;
               w_rsp_err  = 1'b0;
               if (bus.CMD_BE == 2'b00) begin
                  w_state     = S_RESP;
                  w_rsp_valid = 1'b1;
                  w_rsp_err   = 1'b1;
               end else begin
                  w_state = S_SETUP;
                  w_a     = bus.CMD_ADDR;
                  w_rnw   = bus.CMD_RNW;
                  w_di    = bus.CMD_RNW ? 16'h0000 : bus.CMD_DATA;
               end
            end
         end
         S_SETUP: begin
            if (r_cnt == SETUP_LAST) begin
               w_state = S_STROBE;
               w_cnt   = '0;
               w_sel   = 1'b1;
               w_uds_n = ~r_be[1];
               w_lds_n = ~r_be[0];
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_STROBE: begin
            if (!bus.VDP_DTACK_N) begin
               if (r_rnw) w_rsp_data = bus.VDP_DO & {{8{r_be[1]}}, {8{r_be[0]}}};
               w_release = 1'b1;
            end
`ifdef VDP_BUS_TIMEOUT_EN
            else if (r_cnt == TMO_LAST) begin
               w_rsp_err  = 1'b1;
               w_rsp_data = '0;
               w_release  = 1'b1;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
`endif
         end
         S_RELEASE: begin
            // r_seen splits the state: waiting for DTACK_N high, then recovery.
            if (!r_seen) begin
               if (bus.VDP_DTACK_N) begin
                  w_seen = 1'b1;
                  w_cnt  = '0;
               end
`ifdef VDP_BUS_TIMEOUT_EN
               else if (r_cnt == TMO_LAST) begin
                  w_rsp_err   = 1'b1;
                  w_rsp_data  = '0;
                  w_state     = S_RESP;
                  w_rsp_valid = 1'b1;
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
`endif
            end else if (r_cnt == REC_LAST) begin
               w_state     = S_RESP;
               w_rsp_valid = 1'b1;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_RESP: begin
            if (bus.RSP_READY) begin
               w_state     = S_IDLE;
               w_rsp_valid = 1'b0;
            end
         end
         default: w_state = S_IDLE;
      endcase
      if (w_release) begin
         w_state = S_RELEASE;
         w_cnt   = '0;
         w_seen  = 1'b0;
         w_sel   = 1'b0;
         w_uds_n = 1'b1;
         w_lds_n = 1'b1;
         w_rnw   = 1'b1;
         w_di    = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_seen      <= 1'b0;
         r_be        <= '0;
         r_sel       <= 1'b0;
         r_a         <= '0;
         r_rnw       <= 1'b1;
         r_uds_n     <= 1'b1;
         r_lds_n     <= 1'b1;
         r_di        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_seen      <= w_seen;
         r_be        <= w_be;
         r_sel       <= w_sel;
         r_a         <= w_a;
         r_rnw       <= w_rnw;
         r_uds_n     <= w_uds_n;
         r_lds_n     <= w_lds_n;
         r_di        <= w_di;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_data  <= w_rsp_data;
         r_rsp_err   <= w_rsp_err;
      end
   end

   assign bus.CMD_READY = RST_N && (r_state == S_IDLE);
   assign bus.RSP_VALID = r_rsp_valid;
   assign bus.RSP_DATA  = r_rsp_data;
   assign bus.RSP_ERR   = r_rsp_err;
   assign bus.VDP_SEL   = r_sel;
   assign bus.VDP_A     = r_a;
   assign bus.VDP_RNW   = r_rnw;
   assign bus.VDP_UDS_N = r_uds_n;
   assign bus.VDP_LDS_N = r_lds_n;
   assign bus.VDP_DI    = r_di;
endmodule

// File: tb/tb_vdp_bus_master.sv
// Randomized bench for vdp_bus_master: a simple VDP responder plus a
// transaction-level model of latency, strobe width, data and error.
`timescale 1ns/1ps
module tb_vdp_bus_master;
   localparam int SETUP = 1;
   localparam int REC   = 1;
   localparam int TMO   = 8;
   localparam int BOUND = 400;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vdp_bus_master_if bus ();

   vdp_bus_master #(
      .SETUP_CYCLES(SETUP), .RECOVERY_CYCLES(REC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   // VDP responder: acks after ack_delay cycles of SEL, holds DTACK_N low
   // for rel_delay cycles after SEL drops; junk pulls DTACK_N low while idle.
   int unsigned ack_delay = 0;
   int unsigned rel_delay = 0;
   int unsigned sel_cnt   = 0;
   int unsigned idle_cnt  = 0;
   logic        junk      = 1'b0;
   logic [15:0] vdp_do    = '0;

   always @(posedge clk) begin
      if (bus.VDP_SEL) begin
         sel_cnt  <= sel_cnt + 1;
         idle_cnt <= 0;
      end else begin
         sel_cnt <= 0;
         if (idle_cnt < 10000) idle_cnt <= idle_cnt + 1;
      end
   end
   assign bus.VDP_DTACK_N = bus.VDP_SEL ? !(sel_cnt >= ack_delay) : !(junk || idle_cnt < rel_delay);
   assign bus.VDP_DO      = vdp_do;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: phase lengths straight from the protocol rules.
   task automatic model(input logic rnw, input logic [1:0] be, input logic [15:0] dov,
                        input int ad, input int rd,
                        output int lat, output int sel_c, output logic err, output logic [15:0] dat);
      int   strobe_c;
      logic tmo;
      tmo      = 1'b0;
      strobe_c = ad + 1;
`ifdef VDP_BUS_TIMEOUT_EN
      if (ad >= TMO) begin strobe_c = TMO; tmo = 1'b1; end
`endif
      lat = SETUP + strobe_c + rd + 1 + REC;
`ifdef VDP_BUS_TIMEOUT_EN
      if (rd >= TMO) begin lat = SETUP + strobe_c + TMO; tmo = 1'b1; end
`endif
      sel_c = strobe_c;
      err   = tmo;
      if (be == 2'b00) begin lat = 0; sel_c = 0; err = 1'b1; end
      dat = (rnw && !err) ? (dov & {{8{be[1]}}, {8{be[0]}}}) : 16'h0000;
   endtask

   task automatic chk_rst(input string nm);
      logic [42:0] exp_v;
      exp_v = {1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      chk_eq(nm, {bus.VDP_SEL, bus.VDP_A, bus.VDP_RNW, bus.VDP_UDS_N, bus.VDP_LDS_N, bus.VDP_DI,
                  bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ERR}, exp_v);
   endtask

   task automatic do_txn(input string nm, input logic rnw, input logic [4:0] addr,
                         input logic [15:0] data, input logic [1:0] be, input logic [15:0] dov,
                         input int ad, input int rd, input int hold, input bit pend,
                         input bit early_rdy);
      int          exp_lat, exp_sel, cyc, sel_cyc, bus_bad, w;
      logic        exp_err, h_err;
      logic [15:0] exp_data, h_data;
      model(rnw, be, dov, ad, rd, exp_lat, exp_sel, exp_err, exp_data);
      ack_delay = ad;
      rel_delay = rd;
      vdp_do    = dov;
      junk      = 1'($urandom_range(0, 1));
      bus.CMD_RNW   = rnw;
      bus.CMD_ADDR  = addr;
      bus.CMD_DATA  = data;
      bus.CMD_BE    = be;
      bus.CMD_VALID = 1'b1;
      w = 0;
      while (!bus.CMD_READY && w < BOUND) begin @(posedge clk); #1; w++; end
      chk_eq({nm, "/cmd_ready"}, bus.CMD_READY, 1);
      @(posedge clk); #1;
      bus.CMD_VALID = 1'b0;
      bus.RSP_READY = early_rdy;
      cyc = 0; sel_cyc = 0; bus_bad = 0;
      while (!bus.RSP_VALID && cyc < BOUND) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.VDP_SEL) begin
            sel_cyc++;
            junk = 1'b0;
            if (bus.VDP_A !== addr || bus.VDP_RNW !== rnw || bus.VDP_DI !== (rnw ? 16'h0000 : data) ||
                bus.VDP_UDS_N !== ~be[1] || bus.VDP_LDS_N !== ~be[0]) bus_bad++;
         end else if (bus.VDP_UDS_N !== 1'b1 || bus.VDP_LDS_N !== 1'b1) begin
            bus_bad++;
         end
      end
      junk = 1'b0;
      chk_eq({nm, "/latency"}, cyc, exp_lat);
      chk_eq({nm, "/sel_cycles"}, sel_cyc, exp_sel);
      chk_eq({nm, "/bus_fields"}, bus_bad, 0);
      chk_eq({nm, "/rsp_err"}, bus.RSP_ERR, exp_err);
      chk_eq({nm, "/rsp_data"}, bus.RSP_DATA, exp_data);
      chk_eq({nm, "/bus_idle"}, {bus.VDP_SEL, bus.VDP_UDS_N, bus.VDP_LDS_N, bus.VDP_RNW, bus.VDP_DI},
             {4'b0111, 16'h0000});
      if (be != 2'b00) chk_eq({nm, "/addr_kept"}, bus.VDP_A, addr);
      h_data = bus.RSP_DATA;
      h_err  = bus.RSP_ERR;
      if (hold > 0) begin
         bus.RSP_READY = 1'b0;
         if (pend) begin
            bus.CMD_BE    = 2'b00;
            bus.CMD_VALID = 1'b1;
         end
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk_eq({nm, "/hold"}, {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_DATA, bus.CMD_READY},
                   {1'b1, h_err, h_data, 1'b0});
         end
      end
      bus.RSP_READY = 1'b1;
      @(posedge clk); #1;
      chk_eq({nm, "/rsp_drop"}, bus.RSP_VALID, 0);
      if (pend) begin
         chk_eq({nm, "/pend_ready"}, bus.CMD_READY, 1);
         @(posedge clk); #1;
         bus.CMD_VALID = 1'b0;
         chk_eq({nm, "/pend_rsp"}, {bus.RSP_VALID, bus.RSP_ERR}, 2'b11);
         @(posedge clk); #1;
         chk_eq({nm, "/pend_done"}, bus.RSP_VALID, 0);
      end
      bus.RSP_READY = 1'b0;
   endtask

   initial begin
      int w, odd;
      bus.CMD_VALID = 1'b0;
      bus.CMD_RNW   = 1'b0;
      bus.CMD_ADDR  = '0;
      bus.CMD_DATA  = '0;
      bus.CMD_BE    = '0;
      bus.RSP_READY = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_rst("reset_values");
      chk_eq("reset_cmd_ready_low", bus.CMD_READY, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_eq("reset_cmd_ready", bus.CMD_READY, 1);

      do_txn("wr04", 1'b0, 5'h04, 16'h8144, 2'b11, 16'h0000, 0, 0, 0, 1'b0, 1'b1);
      do_txn("rd00", 1'b1, 5'h00, 16'h1234, 2'b10, 16'hABCD, 3, 0, 0, 1'b0, 1'b0);
      do_txn("be0", 1'b1, 5'h07, 16'h5555, 2'b00, 16'hFFFF, 0, 0, 0, 1'b0, 1'b0);
      do_txn("hold10", 1'b1, 5'h02, 16'h0000, 2'b11, 16'h1357, 1, 2, 10, 1'b1, 1'b0);

      // Reset pulse while the strobes are asserted.
      ack_delay = 6; rel_delay = 0; junk = 1'b0;
      bus.CMD_RNW = 1'b0; bus.CMD_ADDR = 5'h1F; bus.CMD_DATA = 16'hA5A5; bus.CMD_BE = 2'b11;
      bus.CMD_VALID = 1'b1;
      @(posedge clk); #1;
      bus.CMD_VALID = 1'b0;
      w = 0;
      while (!bus.VDP_SEL && w < BOUND) begin @(posedge clk); #1; w++; end
      chk_eq("rst_mid_strobe_seen", bus.VDP_SEL, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_eq("rst_mid_cmd_ready_low", bus.CMD_READY, 0);
      @(posedge clk); #1;
      chk_rst("rst_mid_values");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_eq("rst_mid_cmd_ready", bus.CMD_READY, 1);
      odd = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.RSP_VALID || bus.VDP_SEL) odd++;
      end
      chk_eq("rst_mid_no_rsp", odd, 0);

`ifdef VDP_BUS_TIMEOUT_EN
      do_txn("tmo_strobe", 1'b1, 5'h01, 16'h0000, 2'b11, 16'hBEEF, 1000, 0, 0, 1'b0, 1'b0);
      do_txn("tmo_release", 1'b1, 5'h03, 16'h0000, 2'b01, 16'h00FF, 1, 50, 2, 1'b0, 1'b0);
      do_txn("tmo_edge", 1'b1, 5'h05, 16'h0000, 2'b11, 16'h4321, TMO - 1, TMO - 1, 0, 1'b0, 1'b0);
`endif

      for (int k = 0; k < 40; k++) begin
         logic [1:0] be;
         int         ad, rd;
         be = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
`ifdef VDP_BUS_TIMEOUT_EN
         ad = int'($urandom_range(0, TMO + 1));
         rd = int'($urandom_range(0, TMO + 1));
`else
         ad = int'($urandom_range(0, 4));
         rd = int'($urandom_range(0, 3));
`endif
         do_txn("rand", 1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom), be, 16'($urandom),
                ad, rd, int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
